rx_payload_chk: RTL

//  Parametrised receive payload checker for the tester data path: compares each received payload

---
 rtl/rx_payload_chk.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/rx_payload_chk.sv
// rx_payload_chk
//   Receive payload checker. Compares each valid payload word against a locally
//   generated reference (constant, incrementing, decrementing, PRBS-7/15/23/31)
//   and accumulates bit-error, word and errored-word statistics. PRBS types can
//   optionally self-synchronise to the received stream (HUNT/LOCK).
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   payload_pre     frame start: reseed, clear counters, enter HUNT, latch type/auto
//   payload_seed    reference seed
//   payload_type    reference pattern select
//   payload_auto    PRBS self-sync enable (latched on payload_pre)
//   payload_valid   payload_data/payload_keep valid
//   payload_data    received word, MSB first on the wire
//   payload_keep    byte mask, masked bytes never count as errors
//   payload_lock    LOCK state
//   payload_esum    accumulated bit errors (saturating)
//   payload_wcnt    words checked (saturating)
//   payload_ewcnt   errored words (saturating)
module rx_payload_chk #(
    parameter int DW       = 32,
    parameter int CNT_W    = 32,
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               payload_pre,
    input  logic [DW-1:0]      payload_seed,
    input  logic [2:0]         payload_type,
    input  logic               payload_auto,
    input  logic               payload_valid,
    input  logic [DW-1:0]      payload_data,
    input  logic [DW/8-1:0]    payload_keep,
    output logic               payload_lock,
    output logic [CNT_W-1:0]   payload_esum,
    output logic [CNT_W-1:0]   payload_wcnt,
    output logic [CNT_W-1:0]   payload_ewcnt
);
    localparam int KW = DW / 8;
    localparam int EW = $clog2(DW + 1);
    localparam int SW = CNT_W + EW;

    typedef enum logic {HUNT, LOCK} state_t;

    state_t            state, state_nx;
    logic [3:0]        good_run, good_nx, bad_run, bad_nx;
    logic [2:0]        typ;
    logic              auto_q;
    logic [DW-1:0]     ref_q;
    logic [30:0]       lfsr;
    logic [CNT_W-1:0]  esum, wcnt, ewcnt;

    // Mask of valid bits for an n-stage register held in 31 bits.
    function automatic logic [30:0] len_mask(input int n);
        return 31'((64'd1 << n) - 64'd1);
    endfunction

    // Generate DW PRBS bits MSB first; returns {word, next state}.
    function automatic logic [DW+30:0] prbs_step(input logic [30:0] s_in, input int n,
                                                 input int t, input logic inv);
        logic [30:0]   s;
        logic [DW-1:0] w;
        logic          b;
        s = s_in;
        w = '0;
        for (int i = DW - 1; i >= 0; i--) begin
            b    = s[n-1] ^ s[t-1];
            s    = {s[29:0], b} & len_mask(n);
            w[i] = b ^ inv;
        end
        return {w, s};
    endfunction

    // Rebuild the LFSR state from received bits: shifting the un-inverted
    // received bits in leaves the last n of them as the new state.
    function automatic logic [30:0] prbs_load(input logic [30:0] s_in, input logic [DW-1:0] d,
                                              input int n, input logic inv);
        logic [30:0] s;
        s = s_in;
        for (int i = DW - 1; i >= 0; i--)
            s = {s[29:0], d[i] ^ inv} & len_mask(n);
        return s;
    endfunction

    // All-zero seeds would lock the LFSR up, so they become all ones.
    function automatic logic [30:0] prbs_seed(input logic [30:0] sd, input int n);
        logic [30:0] s;
        s = sd & len_mask(n);
        if (s == '0) s = len_mask(n);
        return s;
    endfunction

    logic [30:0]      seed31, seed_st;
    logic [DW+30:0]   gen;
    logic [30:0]      rld;
    logic             is_prbs;
    logic [DW-1:0]    mask, data_m, exp_w, err;
    logic [EW-1:0]    ecnt;
    logic             word_bad, count, reload;
    logic [CNT_W:0]   wsum, ewsum;
    logic [SW-1:0]    esum_x;

    assign seed31 = 31'(payload_seed);

    always_comb begin
        case (payload_type)
            3'd3:    seed_st = prbs_seed(seed31, 7);
            3'd4:    seed_st = prbs_seed(seed31, 15);
            3'd5:    seed_st = prbs_seed(seed31, 23);
            default: seed_st = prbs_seed(seed31, 31);
        endcase
    end

    always_comb begin
        for (int k = 0; k < KW; k++) mask[8*k +: 8] = {8{payload_keep[k]}};
    end

    assign data_m = payload_data & mask;

    always_comb begin
        gen     = '0;
        rld     = lfsr;
        is_prbs = 1'b1;
        case (typ)
            3'd3: begin gen = prbs_step(lfsr, 7, 6, 1'b0);   rld = prbs_load(lfsr, data_m, 7, 1'b0);  end
            3'd4: begin gen = prbs_step(lfsr, 15, 14, 1'b1); rld = prbs_load(lfsr, data_m, 15, 1'b1); end
            3'd5: begin gen = prbs_step(lfsr, 23, 18, 1'b1); rld = prbs_load(lfsr, data_m, 23, 1'b1); end
            3'd6: begin gen = prbs_step(lfsr, 31, 28, 1'b1); rld = prbs_load(lfsr, data_m, 31, 1'b1); end
            default: is_prbs = 1'b0;
        endcase
    end

    assign exp_w    = is_prbs ? gen[DW+30:31] : ref_q;
    assign err      = (payload_data ^ exp_w) & mask;
    assign ecnt     = EW'($countones(err));
    assign word_bad = |err;
    // With self-sync only LOCK words are trusted enough to count.
    assign count    = payload_valid && (!auto_q || state == LOCK);
    assign reload   = payload_valid && auto_q && state == HUNT && word_bad;

    // State / run-counter next-state logic; frame start wins over data.
    always_comb begin
        state_nx = state;
        good_nx  = good_run;
        bad_nx   = bad_run;
        if (payload_pre) begin
            state_nx = HUNT;
            good_nx  = '0;
            bad_nx   = '0;
        end else if (payload_valid) begin
            if (state == HUNT) begin
                bad_nx = '0;
                if (word_bad) begin
                    good_nx = '0;
                end else if (good_run == 4'(LOCK_CNT - 1)) begin
                    good_nx  = '0;
                    state_nx = LOCK;
                end else begin
                    good_nx = good_run + 4'd1;
                end
            end else begin
                good_nx = '0;
                if (!word_bad) begin
                    bad_nx = '0;
                end else if (bad_run == 4'(LOSS_CNT - 1)) begin
                    bad_nx   = '0;
                    state_nx = HUNT;
                end else begin
                    bad_nx = bad_run + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= HUNT;
            good_run <= '0;
            bad_run  <= '0;
        end else begin
            state    <= state_nx;
            good_run <= good_nx;
            bad_run  <= bad_nx;
        end
    end

    // Saturating adders: carry/overflow bits pin the result at all ones.
    assign wsum   = {1'b0, wcnt} + {{CNT_W{1'b0}}, 1'b1};
    assign ewsum  = {1'b0, ewcnt} + {{CNT_W{1'b0}}, word_bad};
    assign esum_x = SW'(esum) + SW'(ecnt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            typ    <= '0;
            auto_q <= 1'b0;
            ref_q  <= '0;
            lfsr   <= '0;
            esum   <= '0;
            wcnt   <= '0;
            ewcnt  <= '0;
        end else if (payload_pre) begin
            typ    <= payload_type;
            // Self-sync only means anything for the PRBS types.
            auto_q <= payload_auto && (payload_type inside {3'd3, 3'd4, 3'd5, 3'd6});
            ref_q  <= payload_seed;
            lfsr   <= seed_st;
            esum   <= '0;
            wcnt   <= '0;
            ewcnt  <= '0;
        end else if (payload_valid) begin
            if (typ == 3'd1) ref_q <= ref_q + {{(DW-1){1'b0}}, 1'b1};
            if (typ == 3'd2) ref_q <= ref_q - {{(DW-1){1'b0}}, 1'b1};
            if (is_prbs) lfsr <= reload ? rld : gen[30:0];
            if (count) begin
                wcnt  <= wsum[CNT_W] ? '1 : wsum[CNT_W-1:0];
                ewcnt <= ewsum[CNT_W] ? '1 : ewsum[CNT_W-1:0];
                esum  <= (|esum_x[SW-1:CNT_W]) ? '1 : esum_x[CNT_W-1:0];
            end
        end
    end

    assign payload_lock  = (state == LOCK);
    assign payload_esum  = esum;
    assign payload_wcnt  = wcnt;
    assign payload_ewcnt = ewcnt;

endmodule
